// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: loads A, B, Op from switches via debounced buttons and drives the ALU (SEQ_OP_STEP_EN: load in RUN steps Op)
module alu_input_sequencer #(
  parameter int DATA_W          = 4,
  parameter int OP_W            = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_load,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   Op,
  output logic              valid,
  output logic              start,
  output logic [1:0]        stage
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_RUN = 2'b11} state_t;
  state_t state;
  logic [DATA_W-1:0] sw_m, sw_s;
  logic [1:0] btn, press;
  assign btn = {btn_clear, btn_load};
  assign stage = state;
  // two-flop synchroniser for the switch bank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sw_s, sw_m} <= '0;
    else {sw_s, sw_m} <= {sw_m, sw};
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic b_m, b_s, db, db_q;
    logic [CW-1:0] cnt;
    assign press[i] = db & ~db_q;
    // synchronise, then accept a new level only after it holds for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        {b_s, b_m, db, db_q} <= '0;
        cnt <= '0;
      end else begin
        {b_s, b_m} <= {b_m, btn[i]};
        db_q <= db;
        if (b_s == db) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db  <= b_s;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
  end
  // operand capture FSM; clear takes priority over a same-cycle load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_A;
      {A, B, Op, valid, start} <= '0;
    end else if (press[1]) begin
      state <= S_A;
      {A, B, Op, valid, start} <= '0;
    end else begin
      start <= 1'b0;
      if (press[0])
        case (state)
          S_A: begin
            A     <= sw_s;
            state <= S_B;
          end
          S_B: begin
            B     <= sw_s;
            state <= S_OP;
          end
          S_OP: begin
            Op    <= sw_s[OP_W-1:0];
            state <= S_RUN;
            valid <= 1'b1;
            start <= 1'b1;
          end
          default: begin
`ifdef SEQ_OP_STEP_EN
            Op    <= Op + 1'b1;
            start <= 1'b1;
`else
            state <= S_A;
            valid <= 1'b0;
`endif
          end
        endcase
    end
endmodule

// File: tb/tb_alu_input_sequencer.sv
// tb_alu_input_sequencer: table, hand-written and random checks of the operand sequencer
module tb_alu_input_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, btn_load = 1'b0, btn_clear = 1'b0;
  logic [3:0] sw = 4'hF;
  logic [3:0] A, B;
  logic [1:0] Op, stage;
  logic valid, start;
  int passed = 0, total = 0, start_cnt = 0;
  int m_step = 0, m_st = 0;
  logic [3:0] m_a = 0, m_b = 0;
  logic [1:0] m_op = 0;
  typedef struct {
    logic clr;
    logic [3:0] sw;
    logic [1:0] stg;
    logic [3:0] a, b;
    logic [1:0] op;
    logic vld;
    int st;
  } vec_t;
  vec_t tbl[7];

  alu_input_sequencer #(.DATA_W(4), .OP_W(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
    .A(A), .B(B), .Op(Op), .valid(valid), .start(start), .stage(stage)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (start) start_cnt++;

  task automatic check(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic check_all(input string n, input int stg, input int a, input int b, input int op, input int vld, input int st);
    check({n, " stage"}, int'(stage), stg);
    check({n, " A"}, int'(A), a);
    check({n, " B"}, int'(B), b);
    check({n, " Op"}, int'(Op), op);
    check({n, " valid"}, int'(valid), vld);
    check({n, " start"}, start_cnt, st);
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk) sw = v;
    start_cnt = 0;
    repeat (3) @(negedge clk);
    btn_load = 1'b1;
    repeat (10) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk) start_cnt = 0;
    btn_clear = 1'b1;
    repeat (10) @(negedge clk);
    btn_clear = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic model_press(input logic [3:0] v);
    m_st = 0;
    case (m_step)
      0: begin m_a = v; m_step = 1; end
      1: begin m_b = v; m_step = 2; end
      2: begin m_op = v[1:0]; m_step = 3; m_st = 1; end
      default: begin
`ifdef SEQ_OP_STEP_EN
        m_op = m_op + 2'd1;
        m_st = 1;
`else
        m_step = 0;
`endif
      end
    endcase
  endtask

  task automatic model_clear();
    m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_st = 0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'hC, 2'd1, 4'hC, 4'h0, 2'd0, 1'b0, 0};
    tbl[1] = '{1'b0, 4'hA, 2'd2, 4'hC, 4'hA, 2'd0, 1'b0, 0};
    tbl[2] = '{1'b0, 4'h3, 2'd3, 4'hC, 4'hA, 2'd3, 1'b1, 1};
    tbl[3] = '{1'b1, 4'hF, 2'd0, 4'h0, 4'h0, 2'd0, 1'b0, 0};
    tbl[4] = '{1'b0, 4'h5, 2'd1, 4'h5, 4'h0, 2'd0, 1'b0, 0};
    tbl[5] = '{1'b0, 4'h3, 2'd2, 4'h5, 4'h3, 2'd0, 1'b0, 0};
    tbl[6] = '{1'b0, 4'h2, 2'd3, 4'h5, 4'h3, 2'd2, 1'b1, 1};
    repeat (3) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all("idle", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].clr) do_clear();
      else press(tbl[i].sw);
      check_all($sformatf("tbl%0d", i), tbl[i].stg, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].vld, tbl[i].st);
    end
`ifdef SEQ_OP_STEP_EN
    press(4'h0);
    check_all("run step1", 3, 5, 3, 3, 1, 1);
    press(4'h0);
    check_all("run step2", 3, 5, 3, 0, 1, 1);
`else
    press(4'h0);
    check_all("run load", 0, 5, 3, 2, 0, 0);
`endif
    do_clear();
    @(negedge clk) sw = 4'hF;
    start_cnt = 0;
    repeat (3) @(negedge clk);
    btn_load = 1'b1;
    repeat (2) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    btn_load = 1'b1;
    @(negedge clk) btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check_all("glitch", 0, 0, 0, 0, 0, 0);
    press(4'h9);
    @(negedge clk) sw = 4'hF;
    start_cnt = 0;
    repeat (3) @(negedge clk);
    btn_load = 1'b1;
    btn_clear = 1'b1;
    repeat (10) @(negedge clk);
    btn_load = 1'b0;
    btn_clear = 1'b0;
    repeat (10) @(negedge clk);
    check_all("clr+load", 0, 0, 0, 0, 0, 0);
    press(4'h7);
    press(4'h9);
    check_all("pre-rst", 2, 7, 9, 0, 0, 0);
    @(negedge clk) sw = 4'h6;
    start_cnt = 0;
    @(posedge clk) #3;
    rst_n = 1'b0;
    btn_load = 1'b1;
    #1;
    check_all("async rst", 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check_all("held load", 1, 6, 0, 0, 0, 0);
    do_clear();
    model_clear();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] v;
      v = 4'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        do_clear();
        model_clear();
      end else begin
        press(v);
        model_press(v);
      end
      check_all($sformatf("rnd%0d", i), m_step, m_a, m_b, m_op, int'(m_step == 3), m_st);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
